// File: rtl/alu_seq.sv
// Sequential integer ALU: single-step ADD/SUB/logic/shift, iterative MUL (shift-add)
// and DIV (restoring), one start/done transaction at a time, gated by clk_oe.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_oe,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] src0_in,
    input  logic [WIDTH-1:0] src1_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dst_out,
    output logic [WIDTH-1:0] dst_h_out,
    output logic             zero,
    output logic             div0,
    output logic             illegal,
    output logic [1:0]       dbg_state_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SHR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SHL = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(6);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(7);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(8);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_q, mul_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // MUL high partial product / DIV remainder
    logic [WIDTH-1:0] wa_q, wa_d;       // MUL multiplier / DIV dividend->quotient
    logic [WIDTH-1:0] wb_q, wb_d;       // multiplicand / divisor
    logic [WIDTH-1:0] dst_q, dst_d;
    logic [WIDTH-1:0] dst_h_q, dst_h_d;
    logic             zero_q, zero_d;
    logic             div0_q, div0_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_r;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, rem_n, quo_n;

    assign add_sum  = {1'b0, src0_in} + {1'b0, src1_in};
    assign sub_diff = {1'b0, src0_in} - {1'b0, src1_in};

    assign mul_sum = {1'b0, acc_q} + (wa_q[0] ? {1'b0, wb_q} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], wa_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so the subtraction fits in WIDTH bits when taken.
    assign div_r    = {acc_q, wa_q[WIDTH-1]};
    assign div_ge   = div_r >= {1'b0, wb_q};
    assign div_diff = div_r[WIDTH-1:0] - wb_q;
    assign rem_n    = div_ge ? div_diff : div_r[WIDTH-1:0];
    assign quo_n    = {wa_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_d     = mul_q;
        acc_d     = acc_q;
        wa_d      = wa_q;
        wb_d      = wb_q;
        dst_d     = dst_q;
        dst_h_d   = dst_h_q;
        zero_d    = zero_q;
        div0_d    = div0_q;
        illegal_d = illegal_q;

        if (clk_oe) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dst_d     = '0;
                        dst_h_d   = '0;
                        div0_d    = 1'b0;
                        illegal_d = 1'b0;
                        state_d   = ST_DONE;
                        case (op)
                            OP_ADD: begin
                                dst_d   = add_sum[WIDTH-1:0];
                                dst_h_d = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
                            end
                            OP_SUB: begin
                                dst_d   = sub_diff[WIDTH-1:0];
                                dst_h_d = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
                            end
                            OP_MUL, OP_DIV: begin
                                if (op == OP_DIV && src1_in == '0) begin
                                    dst_d   = '1;
                                    dst_h_d = src0_in;
                                    div0_d  = 1'b1;
                                end else begin
                                    acc_d   = '0;
                                    wa_d    = src0_in;
                                    wb_d    = src1_in;
                                    mul_d   = (op == OP_MUL);
                                    cnt_d   = CNT_W'(WIDTH);
                                    state_d = ST_CALC;
                                end
                            end
                            OP_SHR:  dst_d = src0_in >> src1_in;
                            OP_SHL:  dst_d = src0_in << src1_in;
                            OP_XOR:  dst_d = src0_in ^ src1_in;
                            OP_AND:  dst_d = src0_in & src1_in;
                            OP_OR:   dst_d = src0_in | src1_in;
                            default: illegal_d = 1'b1;
                        endcase
                        // CALC ops keep zero cleared until their result lands.
                        zero_d = (state_d == ST_DONE) && (dst_d == '0);
                    end
                end
                ST_CALC: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (mul_q) begin
                        acc_d = mul_hi;
                        wa_d  = mul_lo;
                    end else begin
                        acc_d = rem_n;
                        wa_d  = quo_n;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        if (mul_q) begin
                            dst_d   = mul_lo;
                            dst_h_d = mul_hi;
                            zero_d  = ({mul_hi, mul_lo} == '0);
                        end else begin
                            dst_d   = quo_n;
                            dst_h_d = rem_n;
                            zero_d  = (quo_n == '0);
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mul_q     <= 1'b0;
            acc_q     <= '0;
            wa_q      <= '0;
            wb_q      <= '0;
            dst_q     <= '0;
            dst_h_q   <= '0;
            zero_q    <= 1'b0;
            div0_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mul_q     <= mul_d;
            acc_q     <= acc_d;
            wa_q      <= wa_d;
            wb_q      <= wb_d;
            dst_q     <= dst_d;
            dst_h_q   <= dst_h_d;
            zero_q    <= zero_d;
            div0_q    <= div0_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign dst_out     = dst_q;
    assign dst_h_out   = dst_h_q;
    assign zero        = zero_q;
    assign div0        = div0_q;
    assign illegal     = illegal_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors, immediate assertions per check.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        clk_oe;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src0_in;
    logic [31:0] src1_in;
    logic        busy;
    logic        done;
    logic [31:0] dst_out;
    logic [31:0] dst_h_out;
    logic        zero;
    logic        div0;
    logic        illegal;
    logic [1:0]  dbg_state_o;

    int checks   = 0;
    int failures = 0;
    int lat;
    bit seen_done;

    alu_seq #(.WIDTH(32), .OP_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_oe      (clk_oe),
        .start       (start),
        .op          (op),
        .src0_in     (src0_in),
        .src1_in     (src1_in),
        .busy        (busy),
        .done        (done),
        .dst_out     (dst_out),
        .dst_h_out   (dst_h_out),
        .zero        (zero),
        .div0        (div0),
        .illegal     (illegal),
        .dbg_state_o (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one op and counts enabled edges from the accept edge until done is seen.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit toggle, output int l);
        op      = o;
        src0_in = a;
        src1_in = b;
        start   = 1'b1;
        clk_oe  = 1'b1;
        step();
        start   = 1'b0;
        src0_in = $urandom;
        src1_in = $urandom;
        l = 1;
        while (!done && l < 100) begin
            clk_oe = toggle ? ~clk_oe : 1'b1;
            start  = (toggle && l >= 4 && l <= 6) ? 1'b1 : 1'b0;
            step();
            if (clk_oe) l++;
        end
        start  = 1'b0;
        clk_oe = 1'b1;
        chk("no_timeout", {63'd0, (l < 100)}, 64'd1);
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        rst = 1'b0; clk_oe = 1'b1; start = 1'b0; op = '0; src0_in = '0; src1_in = '0;
        #2;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dst", {dst_h_out, dst_out}, 64'd0);
        chk("rst_flags", {61'd0, zero, div0, illegal}, 64'd0);
        step(); step();
        rst = 1'b1;
        step();

        // 1: ADD with carry out
        run_op(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
        chk("add_lat", lat, 1);
        chk("add_res", {dst_h_out, dst_out}, 64'h0000_0001_0000_0000);
        chk("add_zero", {63'd0, zero}, 64'd1);
        clk_oe = 1'b0;
        repeat (3) step();
        chk("oe_hold_done", {63'd0, done}, 64'd1);
        clk_oe = 1'b1;
        step();
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("idle_after_done", {63'd0, busy}, 64'd0);
        chk("res_hold", {dst_h_out, dst_out}, 64'h0000_0001_0000_0000);

        // 2: MUL full product
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        chk("mul_lat", lat, 33);
        chk("mul_res", {dst_h_out, dst_out}, 64'hFFFF_FFFE_0000_0001);
        chk("mul_zero", {63'd0, zero}, 64'd0);
        step();

        // 3: DIV then DIV by zero
        run_op(4'd3, 32'd100, 32'd7, 1'b0, lat);
        chk("div_lat", lat, 33);
        chk("div_res", {dst_h_out, dst_out}, {32'd2, 32'd14});
        chk("div_div0", {63'd0, div0}, 64'd0);
        step();
        run_op(4'd3, 32'd5, 32'd0, 1'b0, lat);
        chk("div0_lat", lat, 1);
        chk("div0_res", {dst_h_out, dst_out}, {32'd5, 32'hFFFF_FFFF});
        chk("div0_flag", {63'd0, div0}, 64'd1);
        step();

        // 4: clk_oe toggling during MUL with ignored start pulses
        run_op(4'd2, 32'd6, 32'd7, 1'b1, lat);
        chk("mul_oe_lat", lat, 33);
        chk("mul_oe_res", {dst_h_out, dst_out}, 64'd42);
        chk("div0_cleared", {63'd0, div0}, 64'd0);
        seen_done = 1'b0;
        step();
        repeat (40) begin
            step();
            if (done) seen_done = 1'b1;
        end
        chk("no_second_done", {63'd0, seen_done}, 64'd0);
        chk("mul_oe_idle", {63'd0, busy}, 64'd0);

        // 5: asynchronous reset in the middle of a DIV
        op = 4'd3; src0_in = 32'd100; src1_in = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("div_busy_mid", {63'd0, busy}, 64'd1);
        #3 rst = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_state", {62'd0, dbg_state_o}, 64'd0);
        chk("arst_dst", {dst_h_out, dst_out}, 64'd0);
        chk("arst_flags", {60'd0, done, zero, div0, illegal}, 64'd0);
        step();
        rst = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            step();
            if (done) seen_done = 1'b1;
        end
        chk("aborted_no_done", {63'd0, seen_done}, 64'd0);
        run_op(4'd0, 32'd2, 32'd3, 1'b0, lat);
        chk("add2_lat", lat, 1);
        chk("add2_res", {dst_h_out, dst_out}, 64'd5);
        step();

        // 6: shift boundary, illegal opcode, SUB with borrow
        run_op(4'd5, 32'd1, 32'd32, 1'b0, lat);
        chk("shl32_res", {dst_h_out, dst_out}, 64'd0);
        step();
        run_op(4'd12, 32'h1234, 32'h5678, 1'b0, lat);
        chk("ill_lat", lat, 1);
        chk("ill_flag", {63'd0, illegal}, 64'd1);
        chk("ill_res", {dst_h_out, dst_out}, 64'd0);
        step();
        run_op(4'd1, 32'd3, 32'd5, 1'b0, lat);
        chk("sub_res", {dst_h_out, dst_out}, {32'd1, 32'hFFFF_FFFE});
        chk("ill_cleared", {63'd0, illegal}, 64'd0);
        step();

        // Remaining single-step ops
        run_op(4'd5, 32'd1, 32'd31, 1'b0, lat);
        chk("shl31_res", {dst_h_out, dst_out}, 64'h0000_0000_8000_0000);
        step();
        run_op(4'd4, 32'h8000_0000, 32'd4, 1'b0, lat);
        chk("shr4_res", {dst_h_out, dst_out}, 64'h0000_0000_0800_0000);
        step();
        run_op(4'd4, 32'hFFFF_FFFF, 32'h100, 1'b0, lat);
        chk("shr_big_res", {dst_h_out, dst_out}, 64'd0);
        step();
        run_op(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
        chk("xor_res", {dst_h_out, dst_out}, 64'h0000_0000_0FF0_0FF0);
        step();
        run_op(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
        chk("and_res", {dst_h_out, dst_out}, 64'h0000_0000_F000_F000);
        step();
        run_op(4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
        chk("or_res", {dst_h_out, dst_out}, 64'h0000_0000_FFF0_FFF0);
        step();
        run_op(4'd2, 32'd0, 32'd12345, 1'b0, lat);
        chk("mul0_res", {dst_h_out, dst_out}, 64'd0);
        chk("mul0_zero", {63'd0, zero}, 64'd1);
        step();
        run_op(4'd3, 32'hDEAD_BEEF, 32'h0001_0000, 1'b0, lat);
        chk("div_big_res", {dst_h_out, dst_out}, {32'h0000_BEEF, 32'h0000_DEAD});
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
